// File: rtl/ppu_mem_arbiter_if.sv
// Bus bundle between the PPU/CPU/DMA requesters, the memory macro and ppu_mem_arbiter.
// DMA signals exist only when MEM_ARB_DMA_EN is defined.
interface ppu_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [1:0]        mode_in;
  logic              lcd_en_in;

  logic              ppu_req_in;
  logic [ADDR_W-1:0] ppu_addr_in;
  logic [DATA_W-1:0] ppu_data_out;
  logic              ppu_valid_out;

  logic              cpu_req_in;
  logic              cpu_we_in;
  logic [ADDR_W-1:0] cpu_addr_in;
  logic [DATA_W-1:0] cpu_wdata_in;
  logic [DATA_W-1:0] cpu_rdata_out;
  logic              cpu_ack_out;

  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_re_out;
  logic              mem_we_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic [DATA_W-1:0] mem_rdata_in;
  logic              mem_valid_in;

`ifdef MEM_ARB_DMA_EN
  logic              dma_req_in;
  logic [ADDR_W-1:0] dma_addr_in;
  logic [DATA_W-1:0] dma_wdata_in;
  logic              dma_ack_out;
  logic              dma_active_in;
`endif

  modport slave (
`ifdef MEM_ARB_DMA_EN
    input  dma_req_in, dma_addr_in, dma_wdata_in, dma_active_in,
    output dma_ack_out,
`endif
    input  mode_in, lcd_en_in,
    input  ppu_req_in, ppu_addr_in,
    output ppu_data_out, ppu_valid_out,
    input  cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
    output cpu_rdata_out, cpu_ack_out,
    output mem_addr_out, mem_re_out, mem_we_out, mem_wdata_out,
    input  mem_rdata_in, mem_valid_in
  );

  modport master (
`ifdef MEM_ARB_DMA_EN
    output dma_req_in, dma_addr_in, dma_wdata_in, dma_active_in,
    input  dma_ack_out,
`endif
    output mode_in, lcd_en_in,
    output ppu_req_in, ppu_addr_in,
    input  ppu_data_out, ppu_valid_out,
    output cpu_req_in, cpu_we_in, cpu_addr_in, cpu_wdata_in,
    input  cpu_rdata_out, cpu_ack_out,
    input  mem_addr_out, mem_re_out, mem_we_out, mem_wdata_out,
    output mem_rdata_in, mem_valid_in
  );
endinterface

// File: rtl/ppu_mem_arbiter.sv
// Single-port VRAM/OAM arbiter for PPU, CPU and optional OAM DMA with DMG mode locking.
// Define MEM_ARB_DMA_EN to add the top-priority, write-only DMA requester.
module ppu_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 7
) (
  input logic              clk_in,
  input logic              rst_n_in,
  ppu_mem_arbiter_if.slave bus
);
  localparam int                CNT_W      = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_PPU, OWN_CPU, OWN_DMA} owner_t;

  state_t            state, state_nxt;
  owner_t            owner;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              cpu_ack_q, ppu_valid_q;
  logic [DATA_W-1:0] cpu_rdata_q, ppu_data_q;

  logic              cpu_is_vram, cpu_is_oam, cpu_locked;
  logic              ppu_go, cpu_go;
  logic              grant_dma, grant_ppu, grant_cpu, grant_cpu_locked;
  logic              rd_done, rd_abort;
  logic [DATA_W-1:0] rd_data;
  logic              mem_re, mem_we, cpu_wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  logic              dma_req, dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;

`ifdef MEM_ARB_DMA_EN
  assign dma_req         = bus.dma_req_in;
  assign dma_addr        = bus.dma_addr_in;
  assign dma_wdata       = bus.dma_wdata_in;
  assign dma_lock        = bus.dma_active_in;
  assign bus.dma_ack_out = (state == ISSUE) && (owner == OWN_DMA);
`else
  assign dma_req   = 1'b0;
  assign dma_addr  = '0;
  assign dma_wdata = '0;
  assign dma_lock  = 1'b0;
`endif

  assign cpu_is_vram = (bus.cpu_addr_in >= ADDR_W'(16'h8000)) && (bus.cpu_addr_in <= ADDR_W'(16'h9FFF));
  assign cpu_is_oam  = (bus.cpu_addr_in >= ADDR_W'(16'hFE00)) && (bus.cpu_addr_in <= ADDR_W'(16'hFE9F));
  assign cpu_locked  = (bus.lcd_en_in && ((cpu_is_oam && bus.mode_in[1]) ||
                                          (cpu_is_vram && (bus.mode_in == 2'd3))))
                     || (cpu_is_oam && dma_lock);

  // A requester whose valid/ack is pulsing this cycle still holds req; masking stops a double grant.
  assign ppu_go           = bus.ppu_req_in && !ppu_valid_q;
  assign cpu_go           = bus.cpu_req_in && !cpu_ack_q;
  assign grant_dma        = (state == IDLE) && dma_req;
  assign grant_ppu        = (state == IDLE) && !dma_req && ppu_go;
  assign grant_cpu        = (state == IDLE) && !dma_req && !ppu_go && cpu_go && !cpu_locked;
  assign grant_cpu_locked = (state == IDLE) && !dma_req && !ppu_go && cpu_go && cpu_locked;

  assign rd_done  = (state == WAIT) && bus.mem_valid_in;
  assign rd_abort = (state == WAIT) && !bus.mem_valid_in && (wait_cnt == CNT_LAST);
  assign rd_data  = rd_done ? bus.mem_rdata_in : ABORT_DATA;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_wr_ack = 1'b0;
    case (state)
      IDLE: begin
        if (grant_dma || grant_ppu || grant_cpu) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_addr   = addr_q;
        mem_re     = !we_q;
        mem_we     = we_q;
        mem_wdata  = we_q ? wdata_q : '0;
        cpu_wr_ack = we_q && (owner == OWN_CPU);
        state_nxt  = we_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (rd_done || rd_abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      owner       <= OWN_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      wait_cnt    <= '0;
      cpu_ack_q   <= 1'b0;
      ppu_valid_q <= 1'b0;
      cpu_rdata_q <= '0;
      ppu_data_q  <= '0;
    end else begin
      cpu_ack_q   <= 1'b0;
      ppu_valid_q <= 1'b0;

      if (grant_dma) begin
        owner   <= OWN_DMA;
        addr_q  <= dma_addr;
        wdata_q <= dma_wdata;
        we_q    <= 1'b1;
      end else if (grant_ppu) begin
        owner   <= OWN_PPU;
        addr_q  <= bus.ppu_addr_in;
        wdata_q <= '0;
        we_q    <= 1'b0;
      end else if (grant_cpu) begin
        owner   <= OWN_CPU;
        addr_q  <= bus.cpu_addr_in;
        wdata_q <= bus.cpu_wdata_in;
        we_q    <= bus.cpu_we_in;
      end

      // Locked CPU access never touches memory: reads see FF, writes vanish.
      if (grant_cpu_locked) begin
        cpu_ack_q <= 1'b1;
        if (!bus.cpu_we_in) cpu_rdata_q <= ABORT_DATA;
      end

      if (state == ISSUE) begin
        wait_cnt <= '0;
        if (we_q) owner <= OWN_NONE;
      end

      if (state == WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
        if (rd_done || rd_abort) begin
          wait_cnt <= '0;
          owner    <= OWN_NONE;
          if (owner == OWN_PPU) begin
            ppu_valid_q <= 1'b1;
            ppu_data_q  <= rd_data;
          end else if (owner == OWN_CPU) begin
            cpu_ack_q   <= 1'b1;
            cpu_rdata_q <= rd_data;
          end
        end
      end
    end
  end

  assign bus.mem_re_out    = mem_re;
  assign bus.mem_we_out    = mem_we;
  assign bus.mem_addr_out  = mem_addr;
  assign bus.mem_wdata_out = mem_wdata;
  assign bus.cpu_ack_out   = cpu_ack_q || cpu_wr_ack;
  assign bus.cpu_rdata_out = cpu_rdata_q;
  assign bus.ppu_valid_out = ppu_valid_q;
  assign bus.ppu_data_out  = ppu_data_q;
endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// Directed bench for ppu_mem_arbiter: memory model with 1-cycle or no response, hand-computed expectations.
// Build with MEM_ARB_DMA_EN to include the DMA steps.
module tb_ppu_mem_arbiter;
  logic       clk_in = 1'b0;
  logic       rst_n_in;
  int         checks = 0;
  int         failures = 0;
  int         lat_cfg = 1;
  logic       model_valid;
  logic       spur_valid = 1'b0;
  logic [7:0] mem [0:65535];

  ppu_mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus();

  ppu_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_TIMEOUT(7)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  assign bus.mem_valid_in = model_valid || spur_valid;

  // Memory answers one cycle after the read strobe when lat_cfg is 1, never when it is 0.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      model_valid      <= 1'b0;
      bus.mem_rdata_in <= 8'h00;
      mem[16'h8000]    <= 8'h55;
      mem[16'h8010]    <= 8'h3C;
      mem[16'h8100]    <= 8'h01;
      mem[16'h8200]    <= 8'h02;
      mem[16'h9FFF]    <= 8'h00;
      mem[16'hFE00]    <= 8'h00;
      mem[16'hFE04]    <= 8'h77;
      mem[16'hFE9F]    <= 8'h66;
      mem[16'hFEA0]    <= 8'h12;
    end else begin
      model_valid <= 1'b0;
      if (bus.mem_we_out) mem[bus.mem_addr_out] <= bus.mem_wdata_out;
      if (bus.mem_re_out && lat_cfg == 1) begin
        model_valid      <= 1'b1;
        bus.mem_rdata_in <= mem[bus.mem_addr_out];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One CPU access: cycles counts edges from request to the ack being visible (-1 if none).
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                               output int cycles, output logic [7:0] rd, output logic strobe);
    logic got;
    bus.cpu_req_in   = 1'b1;
    bus.cpu_we_in    = we;
    bus.cpu_addr_in  = addr;
    bus.cpu_wdata_in = wd;
    cycles = 0;
    strobe = 1'b0;
    got    = 1'b0;
    rd     = 8'h00;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      cycles++;
      if (bus.mem_re_out || bus.mem_we_out) strobe = 1'b1;
      if (bus.cpu_ack_out) begin
        got = 1'b1;
        rd  = bus.cpu_rdata_out;
      end
    end
    bus.cpu_req_in = 1'b0;
    if (!got) cycles = -1;
  endtask

  int         lat, ppu_t, cpu_t, n;
  logic [7:0] rd, ppu_d, cpu_d;
  logic       strobe, seen;

  initial begin
    rst_n_in         = 1'b0;
    bus.mode_in      = 2'd0;
    bus.lcd_en_in    = 1'b1;
    bus.ppu_req_in   = 1'b0;
    bus.ppu_addr_in  = 16'h0000;
    bus.cpu_req_in   = 1'b0;
    bus.cpu_we_in    = 1'b0;
    bus.cpu_addr_in  = 16'h0000;
    bus.cpu_wdata_in = 8'h00;
`ifdef MEM_ARB_DMA_EN
    bus.dma_req_in    = 1'b0;
    bus.dma_addr_in   = 16'h0000;
    bus.dma_wdata_in  = 8'h00;
    bus.dma_active_in = 1'b0;
`endif
    tick();
    tick();
    checkOutput("rst_ppu_valid", bus.ppu_valid_out, 0);
    checkOutput("rst_cpu_ack",   bus.cpu_ack_out,   0);
    checkOutput("rst_mem_re",    bus.mem_re_out,    0);
    checkOutput("rst_mem_we",    bus.mem_we_out,    0);
    checkOutput("rst_mem_addr",  bus.mem_addr_out,  0);
    checkOutput("rst_cpu_rdata", bus.cpu_rdata_out, 0);
    checkOutput("rst_ppu_data",  bus.ppu_data_out,  0);
    rst_n_in = 1'b1;
    tick();

    // Unlocked VRAM read in HBlank: grant, issue, wait, ack.
    bus.mode_in = 2'd0;
    applyStimulus(1'b0, 16'h8010, 8'h00, lat, rd, strobe);
    checkOutput("t1_latency", lat, 3);
    checkOutput("t1_rdata",   rd,  8'h3C);
    checkOutput("t1_strobe",  strobe, 1);
    tick();

    bus.mode_in = 2'd3;
    applyStimulus(1'b1, 16'h8000, 8'hAA, lat, rd, strobe);
    checkOutput("t2_locked_wr_latency", lat, 1);
    checkOutput("t2_locked_wr_strobe",  strobe, 0);
    tick();
    bus.mode_in = 2'd0;
    applyStimulus(1'b0, 16'h8000, 8'h00, lat, rd, strobe);
    checkOutput("t2_old_data", rd, 8'h55);
    tick();

    applyStimulus(1'b1, 16'h9FFF, 8'hA5, lat, rd, strobe);
    checkOutput("wr_latency", lat, 1);
    checkOutput("wr_strobe",  strobe, 1);
    tick();
    applyStimulus(1'b0, 16'h9FFF, 8'h00, lat, rd, strobe);
    checkOutput("wr_readback", rd, 8'hA5);
    tick();

    // OAM locked in mode 2 only while the LCD is on.
    bus.mode_in = 2'd2;
    applyStimulus(1'b0, 16'hFE04, 8'h00, lat, rd, strobe);
    checkOutput("t3_locked_rdata",  rd, 8'hFF);
    checkOutput("t3_locked_strobe", strobe, 0);
    checkOutput("t3_locked_lat",    lat, 1);
    tick();
    bus.lcd_en_in = 1'b0;
    applyStimulus(1'b0, 16'hFE04, 8'h00, lat, rd, strobe);
    checkOutput("t3_lcdoff_rdata",  rd, 8'h77);
    checkOutput("t3_lcdoff_strobe", strobe, 1);
    checkOutput("t3_lcdoff_lat",    lat, 3);
    bus.lcd_en_in = 1'b1;
    tick();

    applyStimulus(1'b0, 16'h8000, 8'h00, lat, rd, strobe);
    checkOutput("vram_mode2_open", rd, 8'h55);
    tick();
    bus.mode_in = 2'd3;
    applyStimulus(1'b0, 16'hFEA0, 8'h00, lat, rd, strobe);
    checkOutput("fea0_unlocked", rd, 8'h12);
    tick();
    applyStimulus(1'b0, 16'hFE9F, 8'h00, lat, rd, strobe);
    checkOutput("fe9f_locked", rd, 8'hFF);
    tick();
    applyStimulus(1'b0, 16'h9FFF, 8'h00, lat, rd, strobe);
    checkOutput("9fff_locked", rd, 8'hFF);
    tick();

    // Simultaneous PPU and CPU requests: PPU first, CPU granted on the IDLE return.
    bus.mode_in      = 2'd1;
    bus.ppu_req_in   = 1'b1;
    bus.ppu_addr_in  = 16'h8100;
    bus.cpu_req_in   = 1'b1;
    bus.cpu_we_in    = 1'b0;
    bus.cpu_addr_in  = 16'h8200;
    ppu_t = -1;
    cpu_t = -1;
    ppu_d = 8'h00;
    cpu_d = 8'h00;
    for (int i = 1; i <= 20 && (ppu_t < 0 || cpu_t < 0); i++) begin
      tick();
      if (bus.ppu_valid_out) begin
        ppu_t = i;
        ppu_d = bus.ppu_data_out;
        bus.ppu_req_in = 1'b0;
      end
      if (bus.cpu_ack_out) begin
        cpu_t = i;
        cpu_d = bus.cpu_rdata_out;
        bus.cpu_req_in = 1'b0;
      end
    end
    bus.ppu_req_in = 1'b0;
    bus.cpu_req_in = 1'b0;
    checkOutput("t4_ppu_time", ppu_t, 3);
    checkOutput("t4_ppu_data", ppu_d, 8'h01);
    checkOutput("t4_cpu_time", cpu_t, 6);
    checkOutput("t4_cpu_data", cpu_d, 8'h02);

    bus.mode_in = 2'd0;
    spur_valid  = 1'b1;
    tick();
    spur_valid  = 1'b0;
    checkOutput("idle_valid_ignored_ack", bus.cpu_ack_out, 0);
    checkOutput("idle_valid_ignored_ppu", bus.ppu_valid_out, 0);
    tick();

    // No memory response: spurious valid during ISSUE must not count, then timeout after 7 WAIT cycles.
    lat_cfg          = 0;
    bus.cpu_req_in   = 1'b1;
    bus.cpu_we_in    = 1'b0;
    bus.cpu_addr_in  = 16'h8010;
    tick();
    checkOutput("t5_issue_re", bus.mem_re_out, 1);
    spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    n    = 2;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.cpu_ack_out) seen = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    rd = bus.cpu_rdata_out;
    bus.cpu_req_in = 1'b0;
    checkOutput("t5_timeout_cycles", seen ? n : -1, 9);
    checkOutput("t5_timeout_data", rd, 8'hFF);
    tick();
    checkOutput("t5_idle_ack", bus.cpu_ack_out, 0);
    checkOutput("t5_idle_re",  bus.mem_re_out, 0);

    // Reset in the middle of WAIT clears outputs and drops the transfer.
    bus.cpu_req_in  = 1'b1;
    bus.cpu_addr_in = 16'h8010;
    tick();
    tick();
    tick();
    rst_n_in = 1'b0;
    #1;
    checkOutput("t6_mem_re",    bus.mem_re_out,    0);
    checkOutput("t6_mem_addr",  bus.mem_addr_out,  0);
    checkOutput("t6_cpu_ack",   bus.cpu_ack_out,   0);
    checkOutput("t6_cpu_rdata", bus.cpu_rdata_out, 0);
    checkOutput("t6_ppu_data",  bus.ppu_data_out,  0);
    bus.cpu_req_in = 1'b0;
    lat_cfg        = 1;
    tick();
    rst_n_in = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.cpu_ack_out || bus.mem_re_out) seen = 1'b1;
    end
    checkOutput("t6_no_late_ack", seen, 0);
    applyStimulus(1'b0, 16'h8010, 8'h00, lat, rd, strobe);
    checkOutput("t6_after_rst_lat",   lat, 3);
    checkOutput("t6_after_rst_rdata", rd, 8'h3C);
    tick();

`ifdef MEM_ARB_DMA_EN
    // DMA writes OAM in mode 2 bypassing the lock, and locks OAM to the CPU while active.
    bus.mode_in       = 2'd2;
    bus.dma_active_in = 1'b1;
    bus.dma_req_in    = 1'b1;
    bus.dma_addr_in   = 16'hFE00;
    bus.dma_wdata_in  = 8'h5A;
    tick();
    checkOutput("dma_ack",      bus.dma_ack_out, 1);
    checkOutput("dma_we",       bus.mem_we_out, 1);
    checkOutput("dma_addr",     bus.mem_addr_out, 16'hFE00);
    bus.dma_req_in = 1'b0;
    tick();
    bus.mode_in = 2'd0;
    applyStimulus(1'b0, 16'hFE00, 8'h00, lat, rd, strobe);
    checkOutput("dma_lock_rdata",  rd, 8'hFF);
    checkOutput("dma_lock_strobe", strobe, 0);
    tick();
    bus.dma_active_in = 1'b0;
    applyStimulus(1'b0, 16'hFE00, 8'h00, lat, rd, strobe);
    checkOutput("dma_written", rd, 8'h5A);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
